// File: rtl/reduction_arbiter.sv
// Round-robin controller for a shared bitwise reduction engine: grants one requester,
// folds its multi-word payload into an accumulator and returns word + reduced bit.
module reduction_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [2*NUM_REQ-1:0]            req_op,
    input  logic [LEN_WIDTH*NUM_REQ-1:0]    req_len,
    output logic [NUM_REQ-1:0]              gnt,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]   in_data,
    input  logic [NUM_REQ-1:0]              in_valid,
    output logic [NUM_REQ-1:0]              in_ready,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [$clog2(NUM_REQ)-1:0]      res_id,
    output logic [DATA_WIDTH-1:0]           res_word,
    output logic                            res_bit,
    output logic [1:0]                      dbg_state_o
);
    localparam int IDW = $clog2(NUM_REQ);

    // Handshakes: a word moves on in_valid[i] && in_ready[i]; a result moves on
    // res_valid && res_ready. Valid never drops and payload never changes until accepted.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]         winner_q, winner_d;
    logic [1:0]             op_q, op_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     in_ready_q, in_ready_d;
    logic                   res_valid_q, res_valid_d;
    logic [IDW-1:0]         res_id_q, res_id_d;
    logic [DATA_WIDTH-1:0]  res_word_q, res_word_d;
    logic                   res_bit_q, res_bit_d;

    logic [DATA_WIDTH-1:0]  data_a [NUM_REQ];
    logic [1:0]             op_a   [NUM_REQ];
    logic [LEN_WIDTH-1:0]   len_a  [NUM_REQ];
    logic                   found;
    logic [IDW-1:0]         pick_idx;
    logic [IDW-1:0]         cand;
    logic                   fire;
    logic                   last_word;
    logic [DATA_WIDTH-1:0]  acc_next;

    function automatic logic red_bit(input logic [DATA_WIDTH-1:0] v, input logic [1:0] op);
        case (op)
            2'b00:   red_bit = &v;
            2'b01:   red_bit = |v;
            2'b10:   red_bit = ^v;
            default: red_bit = ~^v;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_a[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            op_a[i]   = req_op[2*i +: 2];
            len_a[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    // First set request at or above rr_ptr, wrapping around.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign fire      = in_ready_q[winner_q] & in_valid[winner_q];
    assign last_word = (cnt_q == len_q);

    // XNOR accumulates like XOR; only the final reduced bit differs.
    always_comb begin
        acc_next = data_a[winner_q];
        if (cnt_q != '0) begin
            case (op_q)
                2'b00:   acc_next = acc_q & data_a[winner_q];
                2'b01:   acc_next = acc_q | data_a[winner_q];
                default: acc_next = acc_q ^ data_a[winner_q];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            op_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            gnt_q       <= '0;
            in_ready_q  <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_word_q  <= '0;
            res_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            op_q        <= op_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            gnt_q       <= gnt_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_word_q  <= res_word_d;
            res_bit_q   <= res_bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found) state_d = S_BUSY;
            S_BUSY:  if (fire && last_word) state_d = S_DONE;
            S_DONE:  if (res_valid_q && res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        winner_d    = winner_q;
        op_d        = op_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        gnt_d       = gnt_q;
        in_ready_d  = in_ready_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_word_d  = res_word_q;
        res_bit_d   = res_bit_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    winner_d   = pick_idx;
                    op_d       = op_a[pick_idx];
                    len_d      = len_a[pick_idx];
                    cnt_d      = '0;
                    gnt_d      = NUM_REQ'(1) << pick_idx;
                    in_ready_d = NUM_REQ'(1) << pick_idx;
                    rr_ptr_d   = (pick_idx == IDW'(NUM_REQ-1)) ? '0 : pick_idx + IDW'(1);
                end
            end
            S_BUSY: begin
                if (fire) begin
                    acc_d = acc_next;
                    if (last_word) begin
                        in_ready_d  = '0;
                        res_valid_d = 1'b1;
                        res_id_d    = winner_q;
                        res_word_d  = acc_next;
                        res_bit_d   = red_bit(acc_next, op_q);
                    end else begin
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                if (res_valid_q && res_ready) begin
                    gnt_d       = '0;
                    res_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign gnt         = gnt_q;
    assign in_ready    = in_ready_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign res_word    = res_word_q;
    assign res_bit     = res_bit_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reduction_arbiter.sv
// Randomised self-checking bench for reduction_arbiter against a per-bit counting model.
module tb_reduction_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [15:0] req_len;
  logic [3:0]  gnt;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [7:0]  res_word;
  logic        res_bit;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_ptr = 0;
  logic [7:0] words [16];
  int gaps [17];
  logic [1:0] exp_q[$];

  reduction_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_len(req_len),
    .gnt(gnt), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_word(res_word), .res_bit(res_bit), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [7:0] model_word(input logic [1:0] op, input int len);
    logic [7:0] r;
    int c;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      c = 0;
      for (int w = 0; w <= len; w++) if (words[w][b]) c++;
      case (op)
        2'b00:   r[b] = (c == len + 1);
        2'b01:   r[b] = (c > 0);
        default: r[b] = (c % 2 == 1);
      endcase
    end
    return r;
  endfunction

  function automatic logic model_bit(input logic [7:0] v, input logic [1:0] op);
    int ones;
    ones = $countones(v);
    case (op)
      2'b00:   return ones == 8;
      2'b01:   return ones > 0;
      2'b10:   return ones % 2 == 1;
      default: return ones % 2 == 0;
    endcase
  endfunction

  function automatic int model_pick(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[(exp_ptr + i) % 4]) return (exp_ptr + i) % 4;
    return -1;
  endfunction

  function automatic int model_lat(input int len);
    int s;
    s = 1 + len + 1;
    for (int i = 1; i <= len; i++) s += gaps[i];
    return s;
  endfunction

  // driver: runs one job for requester id until res_valid or budget expires
  task automatic run_job(input int id, input logic [1:0] op, input int len, input bit hold_req,
                         output int lat, output int gid, output int bad, output bit to);
    int idx, cyc, gap;
    bit fire;
    req_op[2*id +: 2] = op;
    req_len[4*id +: 4] = 4'(len);
    req[id] = 1'b1;
    idx = 0; cyc = 0; gap = gaps[0]; gid = -1; bad = 0;
    while (!res_valid && cyc < 300) begin
      if (gnt != 4'b0) begin
        if (!$onehot(gnt) || (in_ready & ~gnt) != 4'b0) bad++;
        if (gid < 0) for (int i = 0; i < 4; i++) if (gnt[i]) gid = i;
        if (!hold_req) req[id] = 1'b0;
      end
      if (idx <= len && gap == 0) begin
        in_valid[id] = 1'b1;
        in_data[8*id +: 8] = words[idx];
      end else begin
        in_valid[id] = 1'b0;
      end
      fire = in_ready[id] && in_valid[id];
      @(negedge clk);
      cyc++;
      if (fire) begin
        idx++;
        gap = gaps[idx];
      end else if (!in_valid[id] && gap > 0 && gnt[id]) begin
        gap--;
      end
    end
    in_valid[id] = 1'b0;
    lat = cyc;
    to = !res_valid;
  endtask

  task automatic handshake;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic clear_gaps;
    for (int i = 0; i < 17; i++) gaps[i] = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; req_op = '0; req_len = '0; in_data = '0; in_valid = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (in_ready !== 4'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_cmp++; if (res_word !== 8'h00 || res_bit !== 1'b0 || res_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_result: got word=%h bit=%b id=%0d want 00/0/0", res_word, res_bit, res_id);
    end
    rst_n = 1'b1;
    exp_ptr = 0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd0 || gnt !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: got state=%0d gnt=%b want 0/0000", dbg_state, gnt);
    end
  endtask

  task automatic test_round_robin;
    int lat, gid, bad, id;
    bit to;
    logic [7:0] ew;
    clear_gaps();
    req_op = 8'b01_01_01_01;
    req_len = 16'h1111;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      id = model_pick(4'b1111);
      exp_q.push_back(2'(id));
      exp_ptr = (id + 1) % 4;
    end
    exp_ptr = 0;
    for (int k = 0; k < 5; k++) begin
      id = int'(exp_q.pop_front());
      words[0] = 8'($urandom_range(0, 255));
      words[1] = 8'($urandom_range(0, 255));
      ew = model_word(2'b01, 1);
      run_job(id, 2'b01, 1, 1'b1, lat, gid, bad, to);
      n_cmp++; if (to || gid !== id) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d timeout=%0b want %0d", k, gid, to, id); end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rr_onehot[%0d]: got %0d violations want 0", k, bad); end
      n_cmp++; if (res_word !== ew || res_id !== 2'(id)) begin
        n_fail++; $display("FAIL rr_result[%0d]: got %h/%0d want %h/%0d", k, res_word, res_id, ew, id);
      end
      exp_ptr = (id + 1) % 4;
      handshake();
      if (k == 4) req = 4'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_single_xor;
    int lat, gid, bad;
    bit to;
    logic [7:0] ew;
    clear_gaps();
    words[0] = 8'hD2; words[1] = 8'h0F; words[2] = 8'hFF;
    ew = model_word(2'b10, 2);
    run_job(0, 2'b10, 2, 1'b0, lat, gid, bad, to);
    n_cmp++; if (to || lat !== 4) begin n_fail++; $display("FAIL xor_latency: got %0d timeout=%0b want 4", lat, to); end
    n_cmp++; if (res_word !== 8'h22 || ew !== 8'h22) begin n_fail++; $display("FAIL xor_word: got %h model %h want 22", res_word, ew); end
    n_cmp++; if (res_bit !== model_bit(8'h22, 2'b10) || res_id !== 2'd0) begin
      n_fail++; $display("FAIL xor_bit_id: got %b/%0d want 0/0", res_bit, res_id);
    end
    exp_ptr = 1;
    handshake();
    n_cmp++; if (res_valid !== 1'b0 || gnt !== 4'b0) begin
      n_fail++; $display("FAIL xor_release: got valid=%b gnt=%b want 0/0000", res_valid, gnt);
    end
  endtask

  task automatic test_single_word;
    int lat, gid, bad;
    bit to;
    logic [1:0] op;
    clear_gaps();
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 2'b00 : 2'b11;
      words[0] = 8'hD2;
      run_job(2, op, 0, 1'b0, lat, gid, bad, to);
      n_cmp++; if (to || lat !== 2 || gid !== 2) begin
        n_fail++; $display("FAIL single_timing[%0d]: got lat=%0d gid=%0d want 2/2", k, lat, gid);
      end
      n_cmp++; if (res_word !== 8'hD2 || res_bit !== model_bit(8'hD2, op) || res_id !== 2'd2) begin
        n_fail++; $display("FAIL single_result[%0d]: got %h/%b/%0d want d2/%b/2", k, res_word, res_bit, res_id, model_bit(8'hD2, op));
      end
      exp_ptr = 3;
      handshake();
    end
  endtask

  task automatic test_backpressure;
    int lat, gid, bad;
    bit to;
    clear_gaps();
    words[0] = 8'h00; words[1] = 8'h80; gaps[1] = 2;
    in_valid[3] = 1'b1; in_data[31:24] = 8'hFF;
    run_job(1, 2'b01, 1, 1'b0, lat, gid, bad, to);
    n_cmp++; if (to || lat !== model_lat(1)) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, model_lat(1)); end
    n_cmp++; if (res_word !== 8'h80 || res_bit !== 1'b1 || res_id !== 2'd1) begin
      n_fail++; $display("FAIL bp_result: got %h/%b/%0d want 80/1/1", res_word, res_bit, res_id);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b1 || res_word !== 8'h80 || res_bit !== 1'b1 || res_id !== 2'd1 || gnt !== 4'b0010 || in_ready !== 4'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b w=%h b=%b id=%0d gnt=%b rdy=%b want 1/80/1/1/0010/0000",
                           k, res_valid, res_word, res_bit, res_id, gnt, in_ready);
      end
    end
    exp_ptr = 2;
    handshake();
    in_valid[3] = 1'b0;
  endtask

  task automatic test_reset_mid_job;
    int lat, gid, bad, eid;
    bit to;
    req_op[5:4] = 2'b10; req_len[11:8] = 4'd2; req[2] = 1'b1;
    in_valid[2] = 1'b1; in_data[23:16] = 8'($urandom_range(1, 255));
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_grant: got %b want 0100", gnt); end
    req[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 4'b0 || in_ready !== 4'b0 || res_valid !== 1'b0 || res_word !== 8'h00 || res_bit !== 1'b0 || res_id !== 2'd0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset: got gnt=%b rdy=%b v=%b w=%h b=%b id=%0d st=%0d want all zero",
                         gnt, in_ready, res_valid, res_word, res_bit, res_id, dbg_state);
    end
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 0;
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0 || gnt !== 4'b0) begin n_fail++; $display("FAIL mid_no_result: got v=%b gnt=%b want 0/0000", res_valid, gnt); end
    clear_gaps();
    words[0] = 8'h5A;
    req[3] = 1'b1;
    eid = model_pick(4'b1001);
    run_job(0, 2'b01, 0, 1'b0, lat, gid, bad, to);
    n_cmp++; if (to || gid !== eid || res_id !== 2'(eid)) begin
      n_fail++; $display("FAIL mid_regrant: got gid=%0d id=%0d want %0d", gid, res_id, eid);
    end
    exp_ptr = (eid + 1) % 4;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    req[3] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat, gid, bad, id, len, noise, d;
    bit to;
    logic [1:0] op;
    logic [7:0] ew;
    for (int k = 0; k < 20; k++) begin
      id = $urandom_range(0, 3);
      op = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 5);
      clear_gaps();
      for (int i = 0; i <= len; i++) words[i] = 8'($urandom_range(0, 255));
      for (int i = 1; i <= len; i++) gaps[i] = $urandom_range(0, 2);
      noise = (id + 1) % 4;
      in_valid[noise] = 1'b1;
      in_data[8*noise +: 8] = 8'($urandom_range(0, 255));
      ew = model_word(op, len);
      run_job(id, op, len, 1'b0, lat, gid, bad, to);
      n_cmp++; if (to || gid !== model_pick(4'(1 << id)) || bad !== 0) begin
        n_fail++; $display("FAIL rnd_grant[%0d]: got gid=%0d bad=%0d timeout=%0b want %0d/0/0", k, gid, bad, to, id);
      end
      n_cmp++; if (lat !== model_lat(len)) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", k, lat, model_lat(len)); end
      d = $urandom_range(0, 2);
      repeat (d) @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b1 || res_word !== ew || res_bit !== model_bit(ew, op) || res_id !== 2'(id)) begin
        n_fail++; $display("FAIL rnd_result[%0d]: got v=%b %h/%b/%0d want 1 %h/%b/%0d op=%b len=%0d",
                           k, res_valid, res_word, res_bit, res_id, ew, model_bit(ew, op), id, op, len);
      end
      exp_ptr = (id + 1) % 4;
      handshake();
      in_valid[noise] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_xor();
    test_single_word();
    test_backpressure();
    test_reset_mid_job();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
